seven_seg_display_ctrl: RTL and testbench

Parametrised successor to the fixed four-digit bus-to-display hookup. Captures a datapath bus value into a display register at a rate-limited update tick or on an explicit load. Decodes each 4-bit nibble to hex seven-segment codes with leading-zero blanking and per-digit blink. Sits between CompleteDatapath's Bus and the board's seven-segment pins.

---
 rtl/seven_seg_display_ctrl.sv | 151 +++++++++++++++
 tb/tb_seven_seg_display_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_display_ctrl.sv
// +-----------------------------------------------------------------------------+
// | seven_seg_display_ctrl: captures a bus value at a rate-limited tick or on    |
// | load, decodes hex nibbles to active-low seven-segment codes with leading-    |
// | zero blanking and per-digit blink. SEVSEG_SCAN_EN adds a multiplexed scan.  |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
`default_nettype none

module seven_seg_display_ctrl #(
  parameter int NUM_DIGITS = 4,
  parameter int UPDATE_DIV = 12500000,
  parameter int BLINK_DIV  = 25000000,
  parameter int SCAN_DIV   = 50000
) (
  input  logic                    clk,
  input  logic                    Reset,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  input  logic                    load,
  input  logic                    freeze,
  input  logic                    blank_lz_en,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  output logic [7*NUM_DIGITS-1:0] segs,
  output logic [4*NUM_DIGITS-1:0] value_shown,
  output logic                    update_tick
`ifdef SEVSEG_SCAN_EN
  ,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              scan_seg
`endif
);

  localparam int c_UPD_W = $clog2(UPDATE_DIV);
  localparam int c_BLK_W = $clog2(BLINK_DIV);
  localparam logic [c_UPD_W-1:0] c_UPD_LAST = c_UPD_W'(UPDATE_DIV - 1);
  localparam logic [c_BLK_W-1:0] c_BLK_LAST = c_BLK_W'(BLINK_DIV - 1);

  logic [c_UPD_W-1:0]      r_upd_cnt;
  logic [c_BLK_W-1:0]      r_blink_cnt;
  logic                    r_blink_phase;
  logic                    r_tick;
  logic [4*NUM_DIGITS-1:0] r_value;
  logic [7*NUM_DIGITS-1:0] r_segs;
  logic [7*NUM_DIGITS-1:0] w_segs_next;
  logic [NUM_DIGITS-1:0]   w_lz;
  logic                    w_run;
  logic                    w_upd_wrap;

  assign w_upd_wrap  = (r_upd_cnt == c_UPD_LAST);
  assign segs        = r_segs;
  assign value_shown = r_value;
  assign update_tick = r_tick;

  function automatic logic [6:0] f_decode(input logic [3:0] nib);
    case (nib)
      4'h0:    f_decode = 7'b0000001;
      4'h1:    f_decode = 7'b1001111;
      4'h2:    f_decode = 7'b0010010;
      4'h3:    f_decode = 7'b0000110;
      4'h4:    f_decode = 7'b1001100;
      4'h5:    f_decode = 7'b0100100;
      4'h6:    f_decode = 7'b0100000;
      4'h7:    f_decode = 7'b0001111;
      4'h8:    f_decode = 7'b0000000;
      4'h9:    f_decode = 7'b0000100;
      4'hA:    f_decode = 7'b0001000;
      4'hB:    f_decode = 7'b1100000;
      4'hC:    f_decode = 7'b0110001;
      4'hD:    f_decode = 7'b1000010;
      4'hE:    f_decode = 7'b0110000;
      default: f_decode = 7'b0111000;
    endcase
  endfunction

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      r_upd_cnt     <= '0;
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
      r_tick        <= 1'b0;
      r_value       <= '0;
      r_segs        <= '1;
    end else begin
      r_upd_cnt <= w_upd_wrap ? '0 : r_upd_cnt + c_UPD_W'(1);
      r_tick    <= w_upd_wrap;
      if (r_blink_cnt == c_BLK_LAST) begin
        r_blink_cnt   <= '0;
        r_blink_phase <= ~r_blink_phase;
      end else begin
        r_blink_cnt <= r_blink_cnt + c_BLK_W'(1);
      end
      if (!freeze && (load || w_upd_wrap)) begin
        r_value <= value_in;
      end
      r_segs <= w_segs_next;
    end
  end

  // Walk down from the top digit; a digit is a leading zero while every nibble
  // at or above it is zero. Digit 0 always stays lit.
  always_comb begin
    w_lz  = '0;
    w_run = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      w_run   = w_run && (r_value[4*i +: 4] == 4'h0);
      w_lz[i] = w_run && (i != 0);
    end
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    logic w_blank;
    assign w_blank = (blank_lz_en && w_lz[g]) || (r_blink_phase && blink_mask[g]);
    assign w_segs_next[7*g +: 7] = w_blank ? 7'b1111111 : f_decode(r_value[4*g +: 4]);
  end

`ifdef SEVSEG_SCAN_EN
  localparam int c_SCN_W = $clog2(SCAN_DIV);
  localparam int c_IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [c_SCN_W-1:0] c_SCN_LAST = c_SCN_W'(SCAN_DIV - 1);
  localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(NUM_DIGITS - 1);

  logic [c_SCN_W-1:0]    r_scan_cnt;
  logic [c_IDX_W-1:0]    r_scan_idx;
  logic [NUM_DIGITS-1:0] r_an;
  logic [6:0]            r_scan_seg;

  assign an       = r_an;
  assign scan_seg = r_scan_seg;

  // an and scan_seg both follow the index held before the edge, keeping them aligned.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      r_scan_cnt <= '0;
      r_scan_idx <= '0;
      r_an       <= '1;
      r_scan_seg <= 7'b1111111;
    end else begin
      if (r_scan_cnt == c_SCN_LAST) begin
        r_scan_cnt <= '0;
        r_scan_idx <= (r_scan_idx == c_IDX_LAST) ? '0 : r_scan_idx + c_IDX_W'(1);
      end else begin
        r_scan_cnt <= r_scan_cnt + c_SCN_W'(1);
      end
      r_an       <= ~(NUM_DIGITS'(1) << r_scan_idx);
      r_scan_seg <= r_segs[7*int'(r_scan_idx) +: 7];
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_seven_seg_display_ctrl.sv
// +-----------------------------------------------------------------------------+
// | tb_seven_seg_display_ctrl: randomized scoreboard bench for the seven-segment |
// | display controller against a cycle-count based reference model.             |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
`default_nettype none

module tb_seven_seg_display_ctrl;

  localparam int N  = 4;
  localparam int UD = 4;
  localparam int BD = 8;
  localparam int SD = 3;

  logic          clk = 1'b0;
  logic          Reset = 1'b0;
  logic [15:0]   value_in = 16'h0;
  logic          load = 1'b0;
  logic          freeze = 1'b0;
  logic          blank_lz_en = 1'b0;
  logic [3:0]    blink_mask = 4'h0;
  logic [27:0]   segs;
  logic [15:0]   value_shown;
  logic          update_tick;
`ifdef SEVSEG_SCAN_EN
  logic [3:0]    an;
  logic [6:0]    scan_seg;
`endif

  seven_seg_display_ctrl #(
    .NUM_DIGITS(N), .UPDATE_DIV(UD), .BLINK_DIV(BD), .SCAN_DIV(SD)
  ) dut (
    .clk(clk), .Reset(Reset), .value_in(value_in), .load(load), .freeze(freeze),
    .blank_lz_en(blank_lz_en), .blink_mask(blink_mask), .segs(segs),
    .value_shown(value_shown), .update_tick(update_tick)
`ifdef SEVSEG_SCAN_EN
    , .an(an), .scan_seg(scan_seg)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [27:0] segs;
    logic [15:0] shown;
    logic        tick;
    logic [3:0]  an;
    logic [6:0]  scan_seg;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;

  logic [6:0] seg_tab [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                               7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                               7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                               7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Display image from the rules: digits above the highest non-zero nibble are
  // leading zeros; blink blanks masked digits in the odd half-period.
  function automatic logic [27:0] ref_segs(input logic [15:0] v, input bit phase,
                                           input bit lz, input logic [3:0] mask);
    int top;
    logic [27:0] r;
    top = 0;
    r   = '1;
    for (int d = 0; d < N; d++) if (v[4*d +: 4] != 4'h0) top = d;
    for (int d = 0; d < N; d++) begin
      if ((lz && d > top) || (phase && mask[d])) r[7*d +: 7] = 7'b1111111;
      else                                        r[7*d +: 7] = seg_tab[v[4*d +: 4]];
    end
    return r;
  endfunction

  int          k;
  logic [15:0] m_shown;
  logic [27:0] m_prev_segs;

  always @(posedge clk or negedge Reset) begin
    exp_t e;
    bit   tick;
    bit   phase;
    int   idx;
    if (!Reset) begin
      k           = 0;
      m_shown     = 16'h0;
      m_prev_segs = '1;
      q.delete();
    end else begin
      tick       = ((k % UD) == UD - 1);
      phase      = (((k / BD) % 2) == 1);
      idx        = (k / SD) % N;
      e.segs     = ref_segs(m_shown, phase, blank_lz_en, blink_mask);
      e.tick     = tick;
      if (!freeze && (load || tick)) m_shown = value_in;
      e.shown    = m_shown;
      e.an       = ~(4'b0001 << idx);
      e.scan_seg = m_prev_segs[7*idx +: 7];
      m_prev_segs = e.segs;
      q.push_back(e);
      k++;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!Reset) begin
      chk("rst_segs", 64'(segs), 64'(28'hFFFFFFF));
      chk("rst_shown", 64'(value_shown), 64'd0);
      chk("rst_tick", 64'(update_tick), 64'd0);
`ifdef SEVSEG_SCAN_EN
      chk("rst_an", 64'(an), 64'hF);
      chk("rst_scan_seg", 64'(scan_seg), 64'h7F);
`endif
    end else if (q.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL underflow: got empty queue, expected an entry at %0t", $time);
    end else begin
      e = q.pop_front();
      chk("segs", 64'(segs), 64'(e.segs));
      chk("value_shown", 64'(value_shown), 64'(e.shown));
      chk("update_tick", 64'(update_tick), 64'(e.tick));
`ifdef SEVSEG_SCAN_EN
      chk("an", 64'(an), 64'(e.an));
      chk("scan_seg", 64'(scan_seg), 64'(e.scan_seg));
`endif
    end
  end

  task automatic pulse_reset();
    @(negedge clk);
    #2 Reset = 1'b0;
    #1;
    chk("async_rst_segs", 64'(segs), 64'(28'hFFFFFFF));
    chk("async_rst_shown", 64'(value_shown), 64'd0);
    chk("async_rst_tick", 64'(update_tick), 64'd0);
`ifdef SEVSEG_SCAN_EN
    chk("async_rst_an", 64'(an), 64'hF);
`endif
    repeat (2) @(negedge clk);
    #2 Reset = 1'b1;
  endtask

  function automatic logic [15:0] pick_value();
    case ($urandom_range(0, 5))
      0:       return 16'h0000;
      1:       return 16'h0070;
      2:       return 16'h1234;
      3:       return 16'hABCD;
      4:       return 16'($urandom());
      default: return 16'($urandom()) >> (4 * $urandom_range(0, 3));
    endcase
  endfunction

  initial begin
    value_in = 16'h1234;
    repeat (3) @(negedge clk);
    #2 Reset = 1'b1;
    repeat (12) @(negedge clk);
    value_in = 16'hABCD;
    load     = 1'b1;
    @(negedge clk);
    load     = 1'b0;
    repeat (6) @(negedge clk);
    freeze   = 1'b1;
    value_in = 16'hFFFF;
    load     = 1'b1;
    @(negedge clk);
    load     = 1'b0;
    repeat (9) @(negedge clk);
    freeze   = 1'b0;
    repeat (6) @(negedge clk);
    blank_lz_en = 1'b1;
    value_in    = 16'h0070;
    repeat (6) @(negedge clk);
    value_in    = 16'h0000;
    repeat (6) @(negedge clk);
    blink_mask  = 4'b0101;
    value_in    = 16'h1234;
    repeat (40) @(negedge clk);
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 3) == 0) value_in = pick_value();
      load   = ($urandom_range(0, 7) == 0);
      freeze = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 15) == 0) blank_lz_en = 1'($urandom());
      if ($urandom_range(0, 15) == 0) blink_mask  = 4'($urandom());
      if (c == 200 || c == 377) pulse_reset();
    end
    load   = 1'b0;
    freeze = 1'b0;
    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
